fc_layer_stream: RTL

Parametrised fully-connected layer engine; successor to the fixed 84-input/10-output FC2 top.
- Inputs arrive as a valid/ready stream instead of parallel Data_in ports.
- OUT_NEURONS parallel signed fixed-point MACs accumulate against per-neuron weight banks loaded by the RISC-V. Bias add, optional ReLU and saturation follow.
- Results stream serially, with index, to the next layer.
- Sits between a conv/FC producer and the next FC or classifier stage.

---
 rtl/fc_layer_stream_if.sv | 24 ++
 rtl/fc_layer_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_stream_if.sv
// Input activation stream and output result stream of the FC layer engine.
// The master side is the producer/consumer pair; the slave side is the engine.
interface fc_layer_stream_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 4
);
    logic                   in_valid;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [INDEX_WIDTH-1:0] out_index;
    logic                   out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index
    );
endinterface

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: OUT_NEURONS parallel fixed-point MACs over
// IN_FEATURES streamed activations, then bias, optional ReLU, saturation, serial output.
module fc_layer_stream #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned IN_FEATURES  = 84,
    parameter int unsigned OUT_NEURONS  = 10,
    parameter int unsigned FRAC_BITS    = 16,
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned ACC_WIDTH    = 2*DATA_WIDTH + $clog2(IN_FEATURES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   riscv_data,
    input  logic [ADDRESS_BITS-1:0] riscv_address,
    input  logic [OUT_NEURONS-1:0]  wm_enable_write,
    input  logic                    bm_enable_write,
    input  logic                    relu_en,
    fc_layer_stream_if.slave        stream,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CNT_W  = $clog2(IN_FEATURES);
    localparam int unsigned WDEPTH = 1 << CNT_W;
    localparam int unsigned IDX_W  = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1;
    localparam int unsigned PROD_W = 2*DATA_WIDTH;
    localparam int unsigned RES_W  = ACC_WIDTH + 1;
    localparam int unsigned TOP_W  = RES_W - DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        FINISH,
        OUTPUT
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]      in_count_q, count_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]      out_index_q, out_index_d;
    logic                  done_q, done_d;
    logic                  acc_clr;
    logic                  load_res;

    logic                  in_hs;
    logic                  out_hs;
    logic                  mac_v_q;
    logic signed [DATA_WIDTH-1:0] in_reg_q;

    logic signed [DATA_WIDTH-1:0] wmem   [OUT_NEURONS][WDEPTH];
    logic signed [DATA_WIDTH-1:0] bias_q [OUT_NEURONS];
    logic signed [DATA_WIDTH-1:0] w_q    [OUT_NEURONS];
    logic signed [ACC_WIDTH-1:0]  acc_q  [OUT_NEURONS];
    logic signed [PROD_W-1:0]     prod_c [OUT_NEURONS];
    logic signed [RES_W-1:0]      sum_c  [OUT_NEURONS];
    logic signed [RES_W-1:0]      clamp_c[OUT_NEURONS];
    logic [TOP_W-1:0]             top_c  [OUT_NEURONS];
    logic [DATA_WIDTH-1:0]        sat_c  [OUT_NEURONS];
    logic [DATA_WIDTH-1:0]        result_q[OUT_NEURONS];

    assign in_hs  = stream.in_valid & in_ready_q;
    assign out_hs = out_valid_q & stream.out_ready;

    assign stream.in_ready  = in_ready_q;
    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign stream.out_index = out_index_q;
    assign busy             = busy_q;
    assign done             = done_q;

    // State register and registered handshake/status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ACCUM;
            in_count_q  <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_count_q  <= count_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        count_d     = in_count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        done_d      = 1'b0;
        acc_clr     = 1'b0;
        load_res    = 1'b0;

        case (state_q)
            ACCUM: begin
                if (in_hs) begin
                    count_d = in_count_q + CNT_W'(1);
                    if (in_count_q == CNT_W'(IN_FEATURES - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = FINISH;
            end
            FINISH: begin
                state_d     = OUTPUT;
                load_res    = 1'b1;
                out_valid_d = 1'b1;
                out_index_d = '0;
                out_data_d  = sat_c[0];
            end
            OUTPUT: begin
                if (out_hs) begin
                    if (out_index_q == IDX_W'(OUT_NEURONS - 1)) begin
                        state_d     = ACCUM;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        acc_clr     = 1'b1;
                        count_d     = '0;
                    end else begin
                        out_index_d = out_index_q + IDX_W'(1);
                        out_data_d  = result_q[out_index_d];
                    end
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        in_ready_d = (state_d == ACCUM);
        busy_d     = (state_d != ACCUM) || (count_d != '0);
    end

    // Full-width signed products, one per neuron
    always_comb begin
        for (int n = 0; n < OUT_NEURONS; n++) begin
            prod_c[n] = PROD_W'(in_reg_q) * PROD_W'(w_q[n]);
        end
    end

    // Rescale, bias, optional ReLU, then saturate into DATA_WIDTH
    always_comb begin
        for (int n = 0; n < OUT_NEURONS; n++) begin
            sum_c[n]   = RES_W'(acc_q[n] >>> FRAC_BITS) + RES_W'(bias_q[n]);
            clamp_c[n] = (relu_en && sum_c[n][RES_W-1]) ? '0 : sum_c[n];
            top_c[n]   = clamp_c[n][RES_W-1:DATA_WIDTH-1];
            if ((&top_c[n]) || !(|top_c[n])) begin
                sat_c[n] = clamp_c[n][DATA_WIDTH-1:0];
            end else if (clamp_c[n][RES_W-1]) begin
                sat_c[n] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                sat_c[n] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end
    end

    // Accumulation pipeline: input capture at the handshake, MAC one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_v_q  <= 1'b0;
            in_reg_q <= '0;
            for (int n = 0; n < OUT_NEURONS; n++) begin
                acc_q[n]    <= '0;
                result_q[n] <= '0;
            end
        end else begin
            mac_v_q <= in_hs;
            if (in_hs) begin
                in_reg_q <= stream.in_data;
            end
            for (int n = 0; n < OUT_NEURONS; n++) begin
                if (acc_clr) begin
                    acc_q[n] <= '0;
                end else if (mac_v_q) begin
                    acc_q[n] <= acc_q[n] + ACC_WIDTH'(prod_c[n]);
                end
                if (load_res) begin
                    result_q[n] <= sat_c[n];
                end
            end
        end
    end

    // Weight/bias storage survives reset; writes are locked out while an inference is in flight
    always_ff @(posedge clk) begin
        for (int n = 0; n < OUT_NEURONS; n++) begin
            if (!busy_q && wm_enable_write[n]) begin
                wmem[n][CNT_W'(riscv_address)] <= riscv_data;
            end
            if (in_hs) begin
                w_q[n] <= wmem[n][in_count_q];
            end
        end
        if (!busy_q && bm_enable_write &&
            (riscv_address < ADDRESS_BITS'(OUT_NEURONS))) begin
            bias_q[IDX_W'(riscv_address)] <= riscv_data;
        end
    end

endmodule
